// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, internal op set, flag layout.
package alu_pkg;

  // External 4-bit opcodes as they appear in in_word[7:4]; each op has two encodings.
  localparam logic [3:0] OPC_ADD_0 = 4'b0100;
  localparam logic [3:0] OPC_ADD_1 = 4'b1100;
  localparam logic [3:0] OPC_SUB_0 = 4'b0101;
  localparam logic [3:0] OPC_SUB_1 = 4'b1101;
  localparam logic [3:0] OPC_AND_0 = 4'b0110;
  localparam logic [3:0] OPC_AND_1 = 4'b1110;
  localparam logic [3:0] OPC_CMP_0 = 4'b0111;
  localparam logic [3:0] OPC_CMP_1 = 4'b1111;
  localparam logic [3:0] OPC_OR_0  = 4'b1000;
  localparam logic [3:0] OPC_OR_1  = 4'b1001;
  localparam logic [3:0] OPC_XOR_0 = 4'b1010;
  localparam logic [3:0] OPC_XOR_1 = 4'b1011;

  // Flag vector layout: {V,N,C,Z}.
  localparam int FLAGS_W = 4;
  localparam int FLG_Z   = 0;
  localparam int FLG_C   = 1;
  localparam int FLG_N   = 2;
  localparam int FLG_V   = 3;

  // Decoded operation carried down the pipeline.
  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_CMP,
    OP_ILL
  } op_e;

  // Map an external opcode onto the internal op set; unknown codes become OP_ILL.
  function automatic op_e decode_op(input logic [3:0] opc);
    op_e op;
    case (opc)
      OPC_ADD_0, OPC_ADD_1: op = OP_ADD;
      OPC_SUB_0, OPC_SUB_1: op = OP_SUB;
      OPC_AND_0, OPC_AND_1: op = OP_AND;
      OPC_CMP_0, OPC_CMP_1: op = OP_CMP;
      OPC_OR_0,  OPC_OR_1:  op = OP_OR;
      OPC_XOR_0, OPC_XOR_1: op = OP_XOR;
      default:              op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {V,N,C,Z} flags from a decoded op.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SAT_EN     = 0,
  parameter int SIGNED_CMP = 0
) (
  input  op_e                op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   res_o,
  output logic [FLAGS_W-1:0] flags_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             a_lt_b;
  logic             a_eq_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  // Extra top bit captures carry-out for ADD and borrow for SUB.
  assign sum    = {1'b0, a_i} + {1'b0, b_i};
  assign diff   = {1'b0, a_i} - {1'b0, b_i};
  assign a_eq_b = (a_i == b_i);
  assign a_lt_b = (SIGNED_CMP != 0) ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

  // Select the operation result, raw carry/borrow and signed overflow.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      OP_ADD: begin
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
        res   = sum[WIDTH-1:0];
        if ((SAT_EN != 0) && carry) res = '1;
      end
      OP_SUB: begin
        carry = diff[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
        res   = diff[WIDTH-1:0];
        if ((SAT_EN != 0) && carry) res = '0;
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_CMP: res = a_eq_b ? '0 : (a_lt_b ? WIDTH'(1) : WIDTH'(2));
      default: res = '0;
    endcase
  end

  // Z and N come from the final (possibly saturated) result; illegal ops report no flags.
  always_comb begin
    flags_o = '0;
    if (op_i != OP_ILL) begin
      flags_o[FLG_Z] = (res == '0);
      flags_o[FLG_N] = res[WIDTH-1];
      flags_o[FLG_C] = carry;
      flags_o[FLG_V] = ovf;
    end
  end

  assign res_o = res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU: stage 1 captures decoded op and operands, stage 2 is the output register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TAG_W      = 4,
  parameter int SAT_EN     = 0,
  parameter int SIGNED_CMP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_word,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Stage 1 registers.
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  // Stage 2 (output) registers.
  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_res_q,     out_res_d;
  logic [3:0]       out_flags_q,   out_flags_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;
  logic             unused_word_bits;

  // Only the opcode nibble of the instruction word is meaningful here.
  assign unused_word_bits = ^in_word[3:0];

  // A stage may advance when its downstream slot is empty or being drained this cycle.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign accept   = in_valid && s1_adv;
  assign in_ready = s1_adv;

  alu_core #(
    .WIDTH      (WIDTH),
    .SAT_EN     (SAT_EN),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_core (
    .op_i    (s1_op_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .res_o   (core_res),
    .flags_o (core_flags)
  );

  // Next-state for both stages: hold unless the stage advances.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_op_d       = s1_op_q;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    s1_tag_d      = s1_tag_q;
    out_valid_d   = out_valid_q;
    out_res_d     = out_res_q;
    out_flags_d   = out_flags_q;
    out_illegal_d = out_illegal_q;
    out_tag_d     = out_tag_q;

    if (s1_adv) s1_valid_d = in_valid;
    if (accept) begin
      s1_op_d  = decode_op(in_word[7:4]);
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_tag_d = in_tag;
    end

    if (s2_adv) out_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      out_res_d     = core_res;
      out_flags_d   = core_flags;
      out_illegal_d = (s1_op_q == OP_ILL);
      out_tag_d     = s1_tag_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_res_q     <= '0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      out_valid_q   <= out_valid_d;
      out_res_q     <= out_res_d;
      out_flags_q   <= out_flags_d;
      out_illegal_q <= out_illegal_d;
      out_tag_q     <= out_tag_d;
    end
  end

  // Stage 1 payload registers, qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are left unreset on purpose; s1_valid_q already marks them meaningless after reset.
    s1_op_q  <= s1_op_d;
    s1_a_q   <= s1_a_d;
    s1_b_q   <= s1_b_d;
    s1_tag_q <= s1_tag_d;
  end

  assign out_valid   = out_valid_q;
  assign out_res     = out_res_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: two instances (wrapping/unsigned and saturating/signed)
// share one stimulus stream; expected results come from an arithmetic reference model.
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_word = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b1;

  logic          in_ready0, in_ready1;
  logic          out_valid0, out_valid1;
  logic [W-1:0]  out_res0, out_res1;
  logic [3:0]    flags0, flags1;
  logic          ill0, ill1;
  logic [TW-1:0] tag0, tag1;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flags;
    logic       ill;
    logic [3:0] tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  bit         prev_stall [2];
  logic [7:0] prev_res   [2];
  logic [3:0] prev_flags [2];
  logic [3:0] prev_tag   [2];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(TW), .SAT_EN(0), .SIGNED_CMP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_word(in_word),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
    .out_res(out_res0), .out_flags(flags0), .out_illegal(ill0), .out_tag(tag0)
  );

  alu_pipe #(.WIDTH(W), .TAG_W(TW), .SAT_EN(1), .SIGNED_CMP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_word(in_word),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
    .out_res(out_res1), .out_flags(flags1), .out_illegal(ill1), .out_tag(tag1)
  );

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the opcode table.
  function automatic exp_t model(input logic [7:0] word, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] tag, input bit sat, input bit sgn);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    bit c, v, legal;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; c = 0; v = 0; legal = 1;
    case (word[7:4])
      4'd4, 4'd12: begin
        r = ua + ub; s = sa + sb;
        c = (r > 255); v = (s > 127) || (s < -128);
        r = r & 255;
        if (sat && c) r = 255;
      end
      4'd5, 4'd13: begin
        r = ua - ub; s = sa - sb;
        c = (ua < ub); v = (s > 127) || (s < -128);
        r = r & 255;
        if (sat && c) r = 0;
      end
      4'd6, 4'd14: r = ua & ub;
      4'd8, 4'd9:  r = ua | ub;
      4'd10, 4'd11: r = ua ^ ub;
      4'd7, 4'd15: begin
        if (sgn) r = (sa == sb) ? 0 : ((sa < sb) ? 1 : 2);
        else     r = (ua == ub) ? 0 : ((ua < ub) ? 1 : 2);
      end
      default: legal = 0;
    endcase
    e.tag = tag;
    if (legal) begin
      e.res   = r[7:0];
      e.ill   = 1'b0;
      e.flags = {v, (r >= 128), c, (r == 0)};
    end else begin
      e.res   = 8'h00;
      e.ill   = 1'b1;
      e.flags = 4'h0;
    end
    return e;
  endfunction

  // Issue side: push the expected response for every accepted operation.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else if (in_valid && in_ready0) begin
      q0.push_back(model(in_word, in_a, in_b, in_tag, 1'b0, 1'b0));
      q1.push_back(model(in_word, in_a, in_b, in_tag, 1'b1, 1'b1));
    end
  end

  task automatic mon(input int d, input logic rdy, input logic v, input logic [7:0] r,
                     input logic [3:0] f, input logic il, input logic [3:0] t);
    int   occ;
    exp_t e;
    occ = (d == 0) ? q0.size() : q1.size();
    // Pipeline holds two ops; with both slots full only a draining output frees a slot.
    check("in_ready", d, rdy, (out_ready || occ < 2));
    if (prev_stall[d]) begin
      check("hold_valid", d, v, 1);
      check("hold_res", d, r, prev_res[d]);
      check("hold_flags", d, f, prev_flags[d]);
      check("hold_tag", d, t, prev_tag[d]);
    end
    prev_stall[d] = v && !out_ready;
    prev_res[d]   = r;
    prev_flags[d] = f;
    prev_tag[d]   = t;
    if (v && out_ready) begin
      if (occ == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output dut%0d: got res 0x%0h tag 0x%0h, expected none", d, r, t);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check("res", d, r, e.res);
        check("flags", d, f, e.flags);
        check("illegal", d, il, e.ill);
        check("tag", d, t, e.tag);
      end
    end
  endtask

  // Monitor: compares whatever the DUTs present, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall[0] = 0;
      prev_stall[1] = 0;
    end else begin
      mon(0, in_ready0, out_valid0, out_res0, flags0, ill0, tag0);
      mon(1, in_ready1, out_valid1, out_res1, flags1, ill1, tag1);
    end
  end

  // Present an op and hold it until accepted (bounded).
  task automatic issue(input logic [7:0] w, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    bit r;
    int n;
    n = 0;
    in_valid = 1'b1; in_word = w; in_a = a; in_b = b; in_tag = t;
    do begin
      @(negedge clk);
      r = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    tests++;
    if (!r) begin
      fails++;
      $display("FAIL issue_timeout dut0: got in_ready 0 for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0 || out_valid0 || out_valid1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 0, q0.size() + q1.size(), 0);
  endtask

  // Single op into an empty pipe: not visible after one edge, visible after two.
  task automatic latency_check(input logic [7:0] w, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    out_ready = 1'b1;
    issue(w, a, b, t);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", 0, out_valid0, 0);
    @(negedge clk);
    check("latency_valid", 0, out_valid0, 1);
    check("latency_valid", 1, out_valid1, 1);
  endtask

  initial begin
    bit   r, saw_low;
    int   k;
    logic [7:0] stall_ops [6];

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 0, out_valid0, 0);
    check("rst_res", 0, out_res0, 0);
    check("rst_flags", 0, flags0, 0);
    check("rst_illegal", 0, ill0, 0);
    check("rst_tag", 0, tag0, 0);
    check("rst_valid", 1, out_valid1, 0);
    check("rst_res", 1, out_res1, 0);
    @(posedge clk);
    #1;

    // Directed: overflow ADD then borrowing SUB, back to back.
    out_ready = 1'b1;
    issue(8'h40, 8'h7F, 8'h01, 4'h1);
    issue(8'h50, 8'h00, 8'h01, 4'h2);
    // CMP ordering (unsigned on dut0, signed on dut1) and equal operands.
    issue(8'h70, 8'h80, 8'h01, 4'h3);
    issue(8'hF3, 8'h55, 8'h55, 4'h4);
    // Saturation cases (clamp visible on dut1).
    issue(8'hC0, 8'hF0, 8'h20, 4'h5);
    issue(8'hD0, 8'h10, 8'h20, 4'h6);
    // Bitwise ops and an illegal opcode.
    issue(8'h6F, 8'hF0, 8'h3C, 4'h7);
    issue(8'h90, 8'hF0, 8'h3C, 4'h8);
    issue(8'hA1, 8'hF0, 8'h3C, 4'h9);
    issue(8'h2A, 8'($urandom), 8'($urandom), 4'hA);
    drain();

    latency_check(8'h40, 8'h01, 8'h02, 4'hB);
    drain();

    // Stream six ops with the consumer stalled for cycles 3..6.
    stall_ops = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'hA0};
    k = 0;
    saw_low = 0;
    for (int t = 1; t <= 20; t++) begin
      out_ready = !(t >= 3 && t <= 6);
      in_valid  = (k < 6);
      if (k < 6) begin
        in_word = stall_ops[k];
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
        in_tag  = 4'(k + 9);
      end
      @(negedge clk);
      r = in_ready0;
      if (!r) saw_low = 1;
      @(posedge clk);
      #1;
      if (in_valid && r) k++;
    end
    check("stall_accepted", 0, k, 6);
    check("stall_in_ready_drop", 0, saw_low, 1);
    drain();

    // Reset with two ops in flight: they must never emerge.
    out_ready = 1'b0;
    issue(8'h40, 8'h11, 8'h22, 4'hC);
    issue(8'h50, 8'h33, 8'h11, 4'hD);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 0, out_valid0, 0);
    check("post_rst_valid", 1, out_valid1, 0);
    @(posedge clk);
    #1;
    latency_check(8'hE0, 8'h5A, 8'h0F, 4'hE);
    drain();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_word   = 8'($urandom);
      in_a      = 8'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? in_a : 8'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
